// File: rtl/pulse_cmd_decoder.sv
// Byte-stream command decoder: turns framed UART write commands into pulse
// generator parameters, acks each update and drops frames that stall mid-way.
module pulse_cmd_decoder #(
    parameter int unsigned TIMEOUT    = 120000,
    parameter logic [31:0] DEF_PERIOD = 32'h00040000,
    parameter logic [15:0] DEF_P1W    = 16'd30,
    parameter logic [15:0] DEF_P2W    = 16'd60,
    parameter logic [15:0] DEF_DEL    = 16'd200,
    parameter logic [7:0]  DEF_CPMG   = 8'd4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] period,
    output logic [15:0] p1width,
    output logic [15:0] delay,
    output logic [15:0] p2width,
    output logic [15:0] nut_del,
    output logic [7:0]  nut_wid,
    output logic [7:0]  pulse_block,
    output logic [15:0] pulse_block_off,
    output logic [7:0]  cpmg,
    output logic        block,
    output logic        rx_done,
    output logic        cmd_err
);

    typedef enum logic [1:0] {IDLE, DATA, APPLY} state_e;

    // Timer counts idle DATA cycles 0..TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [2:0]    count_q, count_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   shift_q, shift_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [31:0] period_q, period_d;
    logic [15:0] p1width_q, p1width_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] p2width_q, p2width_d;
    logic [15:0] nut_del_q, nut_del_d;
    logic [7:0]  nut_wid_q, nut_wid_d;
    logic [7:0]  pulse_block_q, pulse_block_d;
    logic [15:0] pulse_block_off_q, pulse_block_off_d;
    logic [7:0]  cpmg_q, cpmg_d;
    logic        block_q, block_d;
    logic        rx_done_q, rx_done_d;
    logic        cmd_err_q, cmd_err_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;

    // Payload length per opcode; zero marks an unknown opcode.
    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            8'h01:                             op_len = 3'd4;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h08: op_len = 3'd2;
            8'h06, 8'h07, 8'h09, 8'h0A:        op_len = 3'd1;
            default:                           op_len = 3'd0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d           = state_q;
        opcode_d          = opcode_q;
        count_d           = count_q;
        idx_d             = idx_q;
        shift_d           = shift_q;
        timer_d           = timer_q;
        period_d          = period_q;
        p1width_d         = p1width_q;
        delay_d           = delay_q;
        p2width_d         = p2width_q;
        nut_del_d         = nut_del_q;
        nut_wid_d         = nut_wid_q;
        pulse_block_d     = pulse_block_q;
        pulse_block_off_d = pulse_block_off_q;
        cpmg_d            = cpmg_q;
        block_d           = block_q;
        rx_done_d         = 1'b0;
        cmd_err_d         = 1'b0;
        tx_data_d         = tx_data_q;
        tx_valid_d        = tx_valid_q;

        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rx_valid) begin
                    if (op_len(rx_data) != 3'd0) begin
                        opcode_d = rx_data;
                        count_d  = op_len(rx_data);
                        idx_d    = '0;
                        shift_d  = '0;
                        state_d  = DATA;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    timer_d               = '0;
                    shift_d[8*idx_q +: 8] = rx_data;
                    idx_d                 = idx_q + 2'd1;
                    count_d               = count_q - 3'd1;
                    if (count_q == 3'd1) state_d = APPLY;
                end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                    timer_d   = '0;
                    count_d   = '0;
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APPLY: begin
                case (opcode_q)
                    8'h01:   period_d          = shift_q;
                    8'h02:   p1width_d         = shift_q[15:0];
                    8'h03:   delay_d           = shift_q[15:0];
                    8'h04:   p2width_d         = shift_q[15:0];
                    8'h05:   nut_del_d         = shift_q[15:0];
                    8'h06:   nut_wid_d         = shift_q[7:0];
                    8'h07:   pulse_block_d     = shift_q[7:0];
                    8'h08:   pulse_block_off_d = shift_q[15:0];
                    8'h09:   cpmg_d            = shift_q[7:0];
                    8'h0A:   block_d           = shift_q[0];
                    default: ;
                endcase
                // A fresh ack overrides both a pending one and a same-cycle accept.
                rx_done_d  = 1'b1;
                tx_data_d  = opcode_q;
                tx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q           <= IDLE;
            opcode_q          <= '0;
            count_q           <= '0;
            idx_q             <= '0;
            shift_q           <= '0;
            timer_q           <= '0;
            period_q          <= DEF_PERIOD;
            p1width_q         <= DEF_P1W;
            delay_q           <= DEF_DEL;
            p2width_q         <= DEF_P2W;
            nut_del_q         <= 16'd100;
            nut_wid_q         <= 8'd100;
            pulse_block_q     <= 8'd50;
            pulse_block_off_q <= 16'd100;
            cpmg_q            <= DEF_CPMG;
            block_q           <= 1'b1;
            rx_done_q         <= 1'b0;
            cmd_err_q         <= 1'b0;
            tx_data_q         <= '0;
            tx_valid_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            opcode_q          <= opcode_d;
            count_q           <= count_d;
            idx_q             <= idx_d;
            shift_q           <= shift_d;
            timer_q           <= timer_d;
            period_q          <= period_d;
            p1width_q         <= p1width_d;
            delay_q           <= delay_d;
            p2width_q         <= p2width_d;
            nut_del_q         <= nut_del_d;
            nut_wid_q         <= nut_wid_d;
            pulse_block_q     <= pulse_block_d;
            pulse_block_off_q <= pulse_block_off_d;
            cpmg_q            <= cpmg_d;
            block_q           <= block_d;
            rx_done_q         <= rx_done_d;
            cmd_err_q         <= cmd_err_d;
            tx_data_q         <= tx_data_d;
            tx_valid_q        <= tx_valid_d;
        end
    end

    assign period          = period_q;
    assign p1width         = p1width_q;
    assign delay           = delay_q;
    assign p2width         = p2width_q;
    assign nut_del         = nut_del_q;
    assign nut_wid         = nut_wid_q;
    assign pulse_block     = pulse_block_q;
    assign pulse_block_off = pulse_block_off_q;
    assign cpmg            = cpmg_q;
    assign block           = block_q;
    assign rx_done         = rx_done_q;
    assign cmd_err         = cmd_err_q;
    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// Directed bench for pulse_cmd_decoder: frames, bad opcode, timeout,
// ack back-pressure and mid-frame reset, all against hand-computed values.
module tb_pulse_cmd_decoder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] period;
    logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
    logic [7:0]  nut_wid, pulse_block, cpmg;
    logic        block, rx_done, cmd_err;

    int n_vec  = 0;
    int n_miss = 0;

    pulse_cmd_decoder #(.TIMEOUT(50)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
        .nut_del(nut_del), .nut_wid(nut_wid), .pulse_block(pulse_block),
        .pulse_block_off(pulse_block_off), .cpmg(cpmg), .block(block),
        .rx_done(rx_done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe one byte; returns 1 ns after the edge that sampled it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_defaults(input string tag);
        check({tag, " period"},  period,          32'h00040000);
        check({tag, " p1width"}, p1width,         30);
        check({tag, " p2width"}, p2width,         60);
        check({tag, " delay"},   delay,           200);
        check({tag, " cpmg"},    cpmg,            4);
        check({tag, " blk_w"},   pulse_block,     50);
        check({tag, " blk_off"}, pulse_block_off, 100);
        check({tag, " nut_wid"}, nut_wid,         100);
        check({tag, " nut_del"}, nut_del,         100);
        check({tag, " block"},   block,           1);
        check({tag, " rx_done"}, rx_done,         0);
        check({tag, " cmd_err"}, cmd_err,         0);
        check({tag, " tx_valid"}, tx_valid,       0);
        check({tag, " tx_data"}, tx_data,         0);
    endtask

    int err_pulses;

    initial begin
        resetn   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        step(3);
        resetn = 1'b1;
        step(2);
        check_defaults("reset");

        // p1width = 0x012C; update lands 2 cycles after last strobe
        send_byte(8'h02); send_byte(8'h2C); send_byte(8'h01);
        check("p1w early", p1width, 30);
        check("rx_done early", rx_done, 0);
        step(1);
        check("p1width", p1width, 300);
        check("p1w rx_done", rx_done, 1);
        check("p1w tx_valid", tx_valid, 1);
        check("p1w tx_data", tx_data, 8'h02);
        check("p1w period kept", period, 32'h00040000);
        check("p1w delay kept", delay, 200);
        step(1);
        check("p1w rx_done once", rx_done, 0);
        check("p1w ack taken", tx_valid, 0);

        send_byte(8'h01); send_byte(8'h78); send_byte(8'h56);
        send_byte(8'h34); send_byte(8'h12);
        step(1);
        check("period", period, 32'h12345678);
        check("period p1w kept", p1width, 300);
        send_byte(8'h0A); send_byte(8'hFE);
        step(1);
        check("block", block, 0);

        // unknown opcode: single error pulse the cycle after the strobe
        send_byte(8'h3F);
        check("bad op cmd_err", cmd_err, 1);
        check("bad op rx_done", rx_done, 0);
        step(1);
        check("bad op cmd_err once", cmd_err, 0);
        check("bad op cpmg kept", cpmg, 4);
        send_byte(8'h09); send_byte(8'h08);
        step(1);
        check("cpmg", cpmg, 8);

        // stalled frame is dropped after 50 idle cycles
        send_byte(8'h03); send_byte(8'hAA);
        err_pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_err) err_pulses++;
            step(1);
        end
        check("timeout pulses", err_pulses, 1);
        check("timeout delay kept", delay, 200);
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h00);
        step(1);
        check("delay after timeout", delay, 16);

        // back-pressure: newer ack overwrites pending one
        tx_ready = 1'b0;
        send_byte(8'h06); send_byte(8'h05);
        step(1);
        check("nut_wid", nut_wid, 5);
        check("bp ack1 data", tx_data, 8'h06);
        send_byte(8'h07); send_byte(8'h09);
        step(3);
        check("pulse_block", pulse_block, 9);
        check("bp tx_valid", tx_valid, 1);
        check("bp tx_data", tx_data, 8'h07);
        tx_ready = 1'b1;
        step(1);
        check("bp accepted", tx_valid, 0);
        step(3);
        check("bp stays idle", tx_valid, 0);

        // reset mid-frame discards it and restores defaults
        send_byte(8'h01); send_byte(8'h11);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        check_defaults("mid reset");
        send_byte(8'h09); send_byte(8'h03);
        step(1);
        check("cpmg after reset", cpmg, 3);
        check("period after reset", period, 32'h00040000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
